// File: rtl/bw_iodll_lpf_pkg.sv
// Shared types and default sizes for the DDR DLL master loop and its delay lines.
package bw_iodll_pkg;

  localparam int CODE_W_DEF    = 5;
  localparam int INIT_CODE_DEF = 16;
  localparam int FILT_W_DEF    = 4;
  localparam int LOCK_CNT_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } dll_state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    UP   = 2'd1,
    DN   = 2'd2
  } step_dir_e;

endpackage

// File: rtl/bw_iodll_lpf_updn_filt.sv
// Signed up/down integrator; emits a one-cycle step pulse on the sample that
// would carry it to +/-TH and clears itself on that same edge.
module bw_iodll_updn_filt #(
  parameter int FILT_W = 4
) (
  input  logic clk,
  input  logic rst_l,
  input  logic clr,
  input  logic active,
  input  logic pd_up,
  input  logic pd_dn,
  output logic step_up,
  output logic step_dn
);

  localparam logic signed [FILT_W-1:0] INTEG_HI = FILT_W'(2**(FILT_W-1) - 1);
  localparam logic signed [FILT_W-1:0] INTEG_LO = FILT_W'(-(2**(FILT_W-1) - 1));
  localparam logic signed [FILT_W-1:0] INTEG_ONE = FILT_W'(1);

  logic signed [FILT_W-1:0] integ_r;
  logic signed [FILT_W-1:0] integ_s;

  // next integrator value and threshold crossing; -TH itself is never stored
  always_comb begin
    integ_s = integ_r;
    step_up = 1'b0;
    step_dn = 1'b0;
    if (clr) begin
      integ_s = '0;
    end else if (active && pd_up && !pd_dn) begin
      if (integ_r == INTEG_HI) begin
        step_up = 1'b1;
        integ_s = '0;
      end else begin
        integ_s = integ_r + INTEG_ONE;
      end
    end else if (active && pd_dn && !pd_up) begin
      if (integ_r == INTEG_LO) begin
        step_dn = 1'b1;
        integ_s = '0;
      end else begin
        integ_s = integ_r - INTEG_ONE;
      end
    end else begin
      integ_s = integ_r;
    end
  end

  // integrator register
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      integ_r <= '0;
    end else begin
      integ_r <= integ_s;
    end
  end

endmodule

// File: rtl/bw_iodll_lpf.sv
// DLL master-loop filter: integrates phase-detector pulses into a 5-bit delay
// code, tracks direction reversals to declare lock, and flags code saturation.
module bw_iodll_lpf
  import bw_iodll_pkg::*;
#(
  parameter int CODE_W    = CODE_W_DEF,
  parameter int FILT_W    = FILT_W_DEF,
  parameter int LOCK_CNT  = LOCK_CNT_DEF,
  parameter int INIT_CODE = INIT_CODE_DEF
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              en,
  input  logic              freeze,
  input  logic              pd_up,
  input  logic              pd_dn,
  output logic [CODE_W-1:0] lpf_out,
  output logic              lock,
  output logic              sat_hi,
  output logic              sat_lo
);

  localparam int REV_W = $clog2(LOCK_CNT + 1);
  localparam logic [REV_W-1:0]  REV_MAX  = REV_W'(LOCK_CNT);
  localparam logic [REV_W-1:0]  REV_ONE  = REV_W'(1);
  localparam logic [CODE_W-1:0] CODE_MAX = {CODE_W{1'b1}};
  localparam logic [CODE_W-1:0] CODE_MIN = {CODE_W{1'b0}};
  localparam logic [CODE_W-1:0] CODE_ONE = CODE_W'(1);
  localparam logic [CODE_W-1:0] CODE_INI = CODE_W'(INIT_CODE);

  dll_state_e        state_r, state_s;
  step_dir_e         dir_r, dir_s, step_dir_s;
  logic [REV_W-1:0]  rev_r, rev_s;
  logic [CODE_W-1:0] code_s;
  logic              step_up_s, step_dn_s;
  logic              filt_clr_s, filt_active_s;

  assign filt_clr_s    = !en || (state_r == IDLE);
  assign filt_active_s = en && !freeze && (state_r != IDLE);

  bw_iodll_updn_filt #(.FILT_W(FILT_W)) u_filt (
    .clk     (clk),
    .rst_l   (rst_l),
    .clr     (filt_clr_s),
    .active  (filt_active_s),
    .pd_up   (pd_up),
    .pd_dn   (pd_dn),
    .step_up (step_up_s),
    .step_dn (step_dn_s)
  );

  // next state, code, reversal count and last step direction
  always_comb begin
    state_s    = state_r;
    dir_s      = dir_r;
    rev_s      = rev_r;
    code_s     = lpf_out;
    step_dir_s = step_up_s ? UP : DN;
    if (!en) begin
      state_s = IDLE;
      dir_s   = NONE;
      rev_s   = '0;
    end else if (freeze) begin
      state_s = state_r;
    end else begin
      case (state_r)
        IDLE: state_s = ACQ;
        ACQ, LOCKED: begin
          // code never wraps; a blocked step still counts for lock tracking
          if (step_up_s && (lpf_out != CODE_MAX)) begin
            code_s = lpf_out + CODE_ONE;
          end else if (step_dn_s && (lpf_out != CODE_MIN)) begin
            code_s = lpf_out - CODE_ONE;
          end else begin
            code_s = lpf_out;
          end
          if (step_up_s || step_dn_s) begin
            dir_s = step_dir_s;
            if (dir_r == step_dir_s) begin
              rev_s = '0;
              if (state_r == LOCKED) begin
                state_s = ACQ;
              end else begin
                state_s = state_r;
              end
            end else if ((dir_r != NONE) && (rev_r != REV_MAX)) begin
              rev_s = rev_r + REV_ONE;
            end else begin
              rev_s = rev_r;
            end
            if ((state_r == ACQ) && (rev_s == REV_MAX)) begin
              state_s = LOCKED;
            end else begin
              state_s = state_s;
            end
          end else begin
            dir_s = dir_r;
          end
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_r <= IDLE;
      dir_r   <= NONE;
      rev_r   <= '0;
      lpf_out <= CODE_INI;
      lock    <= 1'b0;
      sat_hi  <= 1'b0;
      sat_lo  <= 1'b0;
    end else begin
      state_r <= state_s;
      dir_r   <= dir_s;
      rev_r   <= rev_s;
      lpf_out <= code_s;
      lock    <= (state_s == LOCKED);
      sat_hi  <= (code_s == CODE_MAX);
      sat_lo  <= (code_s == CODE_MIN);
    end
  end

endmodule
